// File: rtl/tc_pkg.sv
// Shared definitions for the timer/counter peripheral: register map, CTRL layout,
// mode encodings and FSM states.
package tc_pkg;

  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int IM_BIT   = 3;
  localparam int CTRL_W   = 4;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/timer_counter_dev.sv
// Memory-mapped down-counting timer with one-shot and periodic modes; raises irq
// to the CPU when the count expires.
module timer_counter_dev
  import tc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  preset_q, preset_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              irq_flag_q, irq_flag_d;
  tc_state_e         state_q, state_d;

  logic       en;
  logic [1:0] mode;

  assign en   = ctrl_q[EN_BIT];
  assign mode = ctrl_q[MODE_LSB +: 2];

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = LOAD;
      LOAD:    state_d = CNT;
      CNT: begin
        if (!en)                       state_d = IDLE;
        else if (count_q <= WIDTH'(1)) state_d = INT;
      end
      INT:     state_d = (mode == MODE_PERIODIC) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      LOAD: count_d = preset_q;
      CNT: begin
        if (en) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
          end
        end
      end
      INT: begin
        if (mode == MODE_PERIODIC) irq_flag_d = 1'b0;
        else                       ctrl_d[EN_BIT] = 1'b0;
      end
      default: ;
    endcase

    // CPU writes are applied last so they override the FSM's Enable clear.
    if (we) begin
      case (addr)
        CTRL_OFF: begin
          ctrl_d     = wdata[CTRL_W-1:0];
          irq_flag_d = 1'b0;
        end
        PRESET_OFF: preset_d = wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (addr)
      CTRL_OFF:   rdata = WIDTH'(ctrl_q);
      PRESET_OFF: rdata = preset_q;
      COUNT_OFF:  rdata = count_q;
      default:    rdata = '0;
    endcase
    irq = ctrl_q[IM_BIT] & irq_flag_q;
  end

endmodule
